// File: rtl/ps2_keyboard_decoder_pkg.sv
// Shared constants, frame states and key-event type for the PS/2 keyboard decoder.
// No logic here; only types and a byte classifier.
// Consumers import ps2_keyboard_decoder_pkg::*.
package ps2_keyboard_decoder_pkg;

    localparam logic [7:0] SC_EXT     = 8'hE0;
    localparam logic [7:0] SC_BRK     = 8'hF0;
    localparam logic [7:0] SC_PAUSE   = 8'hE1;
    localparam logic [7:0] SC_BAT_OK  = 8'hAA;
    localparam logic [7:0] SC_ACK     = 8'hFA;
    localparam logic [7:0] SC_ECHO    = 8'hEE;
    localparam logic [7:0] SC_RESEND  = 8'hFE;
    localparam logic [7:0] SC_ERR_LO  = 8'h00;
    localparam logic [7:0] SC_ERR_HI  = 8'hFF;

    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    typedef enum logic [1:0] {
        FRM_IDLE   = 2'd0,
        FRM_DATA   = 2'd1,
        FRM_PARITY = 2'd2,
        FRM_STOP   = 2'd3
    } frame_state_t;

    typedef struct packed {
        logic [7:0] code;
        logic       make;
        logic       ext;
    } key_evt_t;

    // Keyboard status/response bytes carry no key information.
    function automatic logic is_response(input logic [7:0] b);
        return (b == SC_BAT_OK) || (b == SC_ACK) || (b == SC_ECHO) ||
               (b == SC_RESEND) || (b == SC_ERR_LO) || (b == SC_ERR_HI);
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: 2-flop sync, ps2_clk glitch filter, 11-bit frame FSM, abort timeout.
// Latency: rx_done/rx_err are combinational in the cycle the STOP-bit fall is detected.
// Backpressure: none; results are single-cycle pulses. PS2_PARITY_CHECK_EN enables parity/stop checking.
module ps2_frame_rx
    import ps2_keyboard_decoder_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_done,
    output logic       rx_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          clk_flt;
    logic          clk_flt_d;
    logic [FW-1:0] flt_cnt;
    logic [TW-1:0] tmo_cnt;

    frame_state_t  state, state_nxt;
    logic [2:0]    bit_cnt, bit_cnt_nxt;
    logic [7:0]    shreg, shreg_nxt;
    logic          fall;
    logic          bit_in;
    logic          tmo_hit;
    logic          stop_fall;

    // Idle bus is high, so sync and filter come out of reset at 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            dat_sync  <= 2'b11;
            clk_flt   <= 1'b1;
            clk_flt_d <= 1'b1;
            flt_cnt   <= '0;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            dat_sync  <= {dat_sync[0], ps2_data};
            clk_flt_d <= clk_flt;
            if (clk_sync[1] == clk_flt) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
                clk_flt <= clk_sync[1];
                flt_cnt <= '0;
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
        end
    end

    assign fall    = clk_flt_d & ~clk_flt;
    assign bit_in  = dat_sync[1];
    assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset || state == FRM_IDLE || fall) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FRM_IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            shreg   <= shreg_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        stop_fall   = 1'b0;
        case (state)
            FRM_IDLE: begin
                if (fall && !bit_in) begin
                    state_nxt   = FRM_DATA;
                    bit_cnt_nxt = '0;
                    shreg_nxt   = '0;
                end
            end
            FRM_DATA: begin
                if (fall) begin
                    shreg_nxt[bit_cnt] = bit_in;
                    if (bit_cnt == 3'd7) begin
                        state_nxt = FRM_PARITY;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 3'd1;
                    end
                end
            end
            FRM_PARITY: begin
                if (fall) begin
                    state_nxt = FRM_STOP;
                end
            end
            FRM_STOP: begin
                if (fall) begin
                    state_nxt = FRM_IDLE;
                    stop_fall = 1'b1;
                end
            end
            default: state_nxt = FRM_IDLE;
        endcase
        // A stalled partial frame is dropped silently; a fall in the same cycle wins.
        if (state != FRM_IDLE && tmo_hit && !fall) begin
            state_nxt = FRM_IDLE;
        end
    end

    assign rx_byte = shreg;

`ifdef PS2_PARITY_CHECK_EN
    logic par_bit;
    logic frame_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            par_bit <= 1'b0;
        end else if (state == FRM_PARITY && fall) begin
            par_bit <= bit_in;
        end
    end

    // The stop bit is the data level at the STOP fall itself.
    assign frame_ok = bit_in & ((^shreg) ^ par_bit);
    assign rx_done  = stop_fall & frame_ok;
    assign rx_err   = stop_fall & ~frame_ok;
`else
    assign rx_done  = stop_fall;
    assign rx_err   = 1'b0;
`endif

endmodule

// File: rtl/ps2_keyboard_decoder.sv
// PS/2 set-2 keyboard decoder: folds E0/F0 prefixes and the E1 Pause sequence into single key events.
// Latency: key_valid/frame_err pulse 1 clk after the STOP-bit fall is detected.
// Backpressure: none; consumer must take key_valid pulses. PS2_PARITY_CHECK_EN enables frame_err.
module ps2_keyboard_decoder
    import ps2_keyboard_decoder_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode,
    output logic       key_make,
    output logic       key_ext,
    output logic       key_valid,
    output logic       frame_err
);

    logic [7:0] rx_byte;
    logic       rx_done;
    logic       rx_err;

    key_evt_t   evt_q;
    logic       ext_pend;
    logic       brk_pend;
    logic [2:0] skip_cnt;

    ps2_frame_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_frame_rx (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .rx_byte  (rx_byte),
        .rx_done  (rx_done),
        .rx_err   (rx_err)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            evt_q     <= '0;
            ext_pend  <= 1'b0;
            brk_pend  <= 1'b0;
            skip_cnt  <= '0;
            key_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            frame_err <= rx_err;
            if (rx_done) begin
                // Pause bytes are swallowed whole, prefixes included.
                if (skip_cnt != 3'd0) begin
                    skip_cnt <= skip_cnt - 3'd1;
                end else if (rx_byte == SC_EXT) begin
                    ext_pend <= 1'b1;
                end else if (rx_byte == SC_BRK) begin
                    brk_pend <= 1'b1;
                end else if (rx_byte == SC_PAUSE) begin
                    skip_cnt <= PAUSE_SKIP;
                end else if (!is_response(rx_byte)) begin
                    evt_q     <= '{code: rx_byte, make: ~brk_pend, ext: ext_pend};
                    key_valid <= 1'b1;
                    ext_pend  <= 1'b0;
                    brk_pend  <= 1'b0;
                end
            end
        end
    end

    assign keycode  = evt_q.code;
    assign key_make = evt_q.make;
    assign key_ext  = evt_q.ext;

endmodule

// File: tb/tb_ps2_keyboard_decoder.sv
// Directed bench for ps2_keyboard_decoder: 50 MHz clk, 2 us PS/2 bit period, TIMEOUT_CYCLES=2000.
// Expected frame_err/key_valid behaviour follows PS2_PARITY_CHECK_EN.
module tb_ps2_keyboard_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] keycode;
    logic       key_make;
    logic       key_ext;
    logic       key_valid;
    logic       frame_err;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int fall_cyc = 0;
    int v_cnt    = 0;
    int e_cnt    = 0;
    int lat      = -1;
    int v0;
    int e0;

    ps2_keyboard_decoder #(
        .FILTER_LEN     (8),
        .TIMEOUT_CYCLES (2000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .keycode   (keycode),
        .key_make  (key_make),
        .key_ext   (key_ext),
        .key_valid (key_valid),
        .frame_err (frame_err)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            v_cnt++;
            lat = cyc - fall_cyc;
        end
        if (frame_err === 1'b1) e_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One PS/2 bit: data set mid-high, clock low for half the 100-clk period.
    task automatic send_bit(input logic b, input bit glitch);
        @(negedge clk);
        ps2_data = b;
        repeat (25) @(negedge clk);
        ps2_clk  = 1'b0;
        fall_cyc = cyc;
        repeat (50) @(negedge clk);
        ps2_clk = 1'b1;
        if (glitch) begin
            repeat (10) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (3) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (11) @(negedge clk);
        end else begin
            repeat (24) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit glitch);
        logic [10:0] bits;
        bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            send_bit(bits[i], glitch && (i == 5));
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic send_partial(input int nbits);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) begin
            send_bit(1'b1, 1'b0);
        end
    endtask

    task automatic check_evt(input string tag, input int dv, input logic [7:0] code,
                             input logic make, input logic ext);
        check({tag, "_nvalid"}, 32'(v_cnt - v0), 32'(dv));
        check({tag, "_keycode"}, {24'h0, keycode}, {24'h0, code});
        check({tag, "_make"}, {31'h0, key_make}, {31'h0, make});
        check({tag, "_ext"}, {31'h0, key_ext}, {31'h0, ext});
    endtask

    initial begin
        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_keycode", {24'h0, keycode}, 32'h0);
        check("rst_make", {31'h0, key_make}, 32'h0);
        check("rst_ext", {31'h0, key_ext}, 32'h0);
        check("rst_valid", {31'h0, key_valid}, 32'h0);
        check("rst_ferr", {31'h0, frame_err}, 32'h0);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        // 1: plain make code, including pin-to-event latency (2 sync + 8 filter + 1)
        v0 = v_cnt;
        send_frame(8'h1D, 1'b0, 1'b0);
        check_evt("make_1d", 1, 8'h1D, 1'b1, 1'b0);
        check("latency", 32'(lat), 32'd11);

        // 2: break prefix produces no event on its own
        v0 = v_cnt;
        send_frame(8'hF0, 1'b0, 1'b0);
        check("brk_prefix_silent", 32'(v_cnt - v0), 32'd0);
        send_frame(8'h1D, 1'b0, 1'b0);
        check_evt("break_1d", 1, 8'h1D, 1'b0, 1'b0);

        // 3: extended make, extended break
        v0 = v_cnt;
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        check_evt("ext_make_75", 1, 8'h75, 1'b1, 1'b1);
        v0 = v_cnt;
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        check_evt("ext_break_75", 1, 8'h75, 1'b0, 1'b1);

        // Repeated F0 and an interleaved ACK keep the break flag
        v0 = v_cnt;
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'hFA, 1'b0, 1'b0);
        send_frame(8'h1D, 1'b0, 1'b0);
        check_evt("dup_f0_ack_1d", 1, 8'h1D, 1'b0, 1'b0);

        // 4: bad parity frame after a known event
        send_frame(8'h75, 1'b0, 1'b0);
        v0 = v_cnt;
        e0 = e_cnt;
        send_frame(8'h1D, 1'b1, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
        check_evt("bad_par_kept", 0, 8'h75, 1'b1, 1'b0);
        check("bad_par_ferr", 32'(e_cnt - e0), 32'd1);
`else
        check_evt("bad_par_accept", 1, 8'h1D, 1'b1, 1'b0);
        check("bad_par_ferr", 32'(e_cnt - e0), 32'd0);
`endif

        // 5: aborted partial frame, then a frame with a short ps2_clk glitch
        v0 = v_cnt;
        e0 = e_cnt;
        send_partial(4);
        repeat (3000) @(negedge clk);
        check("abort_no_valid", 32'(v_cnt - v0), 32'd0);
        check("abort_no_ferr", 32'(e_cnt - e0), 32'd0);
        send_frame(8'h1C, 1'b0, 1'b1);
        check_evt("after_abort_1c", 1, 8'h1C, 1'b1, 1'b0);

        // 6: reset with pending break and a partial frame in flight
        send_frame(8'hF0, 1'b0, 1'b0);
        send_partial(3);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("rst2_keycode", {24'h0, keycode}, 32'h0);
        check("rst2_make", {31'h0, key_make}, 32'h0);
        check("rst2_ext", {31'h0, key_ext}, 32'h0);
        check("rst2_valid", {31'h0, key_valid}, 32'h0);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        v0 = v_cnt;
        send_frame(8'h1D, 1'b0, 1'b0);
        check_evt("post_rst_1d", 1, 8'h1D, 1'b1, 1'b0);

        // Pause sequence: E1 14 77 E1 F0 14 F0 77 yields nothing
        v0 = v_cnt;
        send_frame(8'hE1, 1'b0, 1'b0);
        send_frame(8'h14, 1'b0, 1'b0);
        send_frame(8'h77, 1'b0, 1'b0);
        send_frame(8'hE1, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h14, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h77, 1'b0, 1'b0);
        check("pause_silent", 32'(v_cnt - v0), 32'd0);
        send_frame(8'h1D, 1'b0, 1'b0);
        check_evt("after_pause_1d", 1, 8'h1D, 1'b1, 1'b0);

`ifdef PS2_PARITY_CHECK_EN
        check("total_ferr", 32'(e_cnt), 32'd1);
`else
        check("total_ferr", 32'(e_cnt), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
